// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side feeder for the 16x16 register file. Completed results
//   (destination register + 16-bit data) arrive over a valid/ready handshake,
//   are buffered in an in-order FIFO of DEPTH entries and drained at most one
//   per cycle into the register file write port. A two-port combinational
//   lookup lets decode forward values that are queued but not yet written.
//
//   Optional feature macro: WB_BYPASS_EN
//     When defined, a result arriving at an empty, unstalled queue is written
//     straight through in the same cycle instead of being enqueued.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   InValid/InReady     producer handshake
//   InReg/InData        destination register and data of the offered result
//   Stall               write port unavailable this cycle (no drain)
//   DstReg/WriteReg/DstData  register file write port
//   QryReg1/QryHit1/QryData1 forwarding lookup, port 1
//   QryReg2/QryHit2/QryData2 forwarding lookup, port 2
//   Count               number of occupied entries
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       InReg,
  input  logic [15:0]      InData,
  input  logic             Stall,
  output logic [3:0]       DstReg,
  output logic             WriteReg,
  output logic [15:0]      DstData,
  input  logic [3:0]       QryReg1,
  output logic             QryHit1,
  output logic [15:0]      QryData1,
  input  logic [3:0]       QryReg2,
  output logic             QryHit2,
  output logic [15:0]      QryData2,
  output logic [PTR_W:0]   Count
);

  typedef struct packed {
    logic        hit;
    logic [15:0] data;
  } qry_t;

  logic [3:0]       reg_q  [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic empty;
  logic accept;
  logic push;
  logic pop;
  logic bypass;
  qry_t qry1, qry2;

  assign empty   = (count_q == '0);
  // Full is judged by occupancy only, so a same-cycle drain never frees a slot
  // for the producer and InReady stays independent of Stall.
  assign InReady = !rst && (count_q < (PTR_W+1)'(DEPTH));
  assign accept  = InValid && InReady;
  assign pop     = !empty && !Stall && !rst;

`ifdef WB_BYPASS_EN
  // Empty queue, free write port: hand the result straight to the register
  // file. R0 results never bypass; they are simply dropped.
  assign bypass = empty && !Stall && InValid && (InReg != 4'd0) && !rst;
`else
  assign bypass = 1'b0;
`endif

  // R0 results complete the handshake but never occupy a slot.
  assign push = accept && (InReg != 4'd0) && !bypass;

  // Pointer and occupancy next-state.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it holding a value and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; count_q masks every
  // unoccupied slot, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail_q]  <= InReg;
      data_q[tail_q] <= InData;
    end
  end

  // Walk occupied entries oldest to youngest; the last match is the youngest.
  function automatic qry_t lookup(input logic [3:0] qry);
    qry_t             r;
    logic [PTR_W-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (qry != 4'd0) && (reg_q[idx] == qry)) begin
        r.hit  = 1'b1;
        r.data = data_q[idx];
      end
    end
    return r;
  endfunction

  always_comb begin
    qry1 = '0;
    qry2 = '0;
    if (!rst) begin
      qry1 = lookup(QryReg1);
      qry2 = lookup(QryReg2);
    end
  end

  assign QryHit1  = qry1.hit;
  assign QryData1 = qry1.data;
  assign QryHit2  = qry2.hit;
  assign QryData2 = qry2.data;

  // Register file write port.
  always_comb begin
    WriteReg = 1'b0;
    DstReg   = 4'd0;
    DstData  = 16'd0;
    if (pop) begin
      WriteReg = 1'b1;
      DstReg   = reg_q[head_q];
      DstData  = data_q[head_q];
    end else if (bypass) begin
      WriteReg = 1'b1;
      DstReg   = InReg;
      DstData  = InData;
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Testbench for reg_writeback_queue (DEPTH=4). Stimulus drives directed
// vectors; a posedge occupancy model pushes each expected register write into
// exp_q, and a negedge monitor pops and compares whenever WriteReg is high.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           InValid;
  logic           InReady;
  logic [3:0]     InReg;
  logic [15:0]    InData;
  logic           Stall;
  logic [3:0]     DstReg;
  logic           WriteReg;
  logic [15:0]    DstData;
  logic [3:0]     QryReg1;
  logic           QryHit1;
  logic [15:0]    QryData1;
  logic [3:0]     QryReg2;
  logic           QryHit2;
  logic [15:0]    QryData2;
  logic [PTR_W:0] Count;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  int          occ = 0;

  reg_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReady(InReady), .InReg(InReg), .InData(InData),
    .Stall(Stall),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
    .QryReg1(QryReg1), .QryHit1(QryHit1), .QryData1(QryData1),
    .QryReg2(QryReg2), .QryHit2(QryHit2), .QryData2(QryData2),
    .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step to just after the next rising edge, where inputs are changed.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Occupancy model: decides what the queue accepts and what it must write.
  initial begin
    logic m_acc, m_byp, m_push, m_pop;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        occ = 0;
      end else begin
        m_acc = InValid && (occ < DEPTH);
        m_byp = 1'b0;
`ifdef WB_BYPASS_EN
        m_byp = (occ == 0) && !Stall && InValid && (InReg != 4'd0);
`endif
        m_push = m_acc && (InReg != 4'd0) && !m_byp;
        m_pop  = (occ != 0) && !Stall;
        if (m_push) exp_q.push_back({InReg, InData});
        occ = occ + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Monitor: compares every register file write against the scoreboard.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      check("count_vs_model", 32'(Count), 32'(occ));
      check("inready_vs_model", 32'(InReady), 32'(!rst && (occ < DEPTH)));
      if (WriteReg) begin
        if (rst) begin
          check("write_during_reset", 32'(WriteReg), 32'd0);
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_reg", 32'(DstReg), 32'(e[19:16]));
          check("write_data", 32'(DstData), 32'(e[15:0]));
        end else begin
`ifdef WB_BYPASS_EN
          if (InValid && (InReg != 4'd0) && !Stall)
            check("bypass_write", {12'd0, DstReg, DstData}, {12'd0, InReg, InData});
          else
            check("unexpected_write", 32'(WriteReg), 32'd0);
`else
          check("unexpected_write", 32'(WriteReg), 32'd0);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cyc;
    logic acc;
    rst = 1'b1; InValid = 1'b0; InReg = 4'd0; InData = 16'd0; Stall = 1'b0;
    QryReg1 = 4'd0; QryReg2 = 4'd0;

    // Reset then idle.
    cycle();
    @(negedge clk);
    check("rst_inready", 32'(InReady), 32'd0);
    check("rst_writereg", 32'(WriteReg), 32'd0);
    cycle();
    @(negedge clk);
    check("rst_count", 32'(Count), 32'd0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("idle_inready", 32'(InReady), 32'd1);
    check("idle_writereg", 32'(WriteReg), 32'd0);
    check("idle_qryhit1", 32'(QryHit1), 32'd0);

    // Single write R3=0xBEEF.
    cycle();
    InValid = 1'b1; InReg = 4'd3; InData = 16'hBEEF;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("single_bypass_wr", {15'd0, WriteReg, DstData}, {15'd0, 1'b1, 16'hBEEF});
`else
    check("single_no_early_wr", 32'(WriteReg), 32'd0);
`endif
    cycle();
    InValid = 1'b0;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("single_count", 32'(Count), 32'd0);
    check("single_wr_n1", 32'(WriteReg), 32'd0);
`else
    check("single_count", 32'(Count), 32'd1);
    check("single_wr_n1", {11'd0, WriteReg, DstReg, DstData}, {11'd0, 1'b1, 4'd3, 16'hBEEF});
`endif
    cycle();
    @(negedge clk);
    check("single_done_count", 32'(Count), 32'd0);

    // Fill and backpressure.
    cycle();
    Stall = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      InValid = 1'b1; InReg = 4'(r); InData = 16'(r);
      cycle();
    end
    InReg = 4'd5; InData = 16'd5;
    @(negedge clk);
    check("full_count", 32'(Count), 32'd4);
    check("full_inready", 32'(InReady), 32'd0);
    cycle();
    @(negedge clk);
    check("full_no_accept", 32'(Count), 32'd4);
    check("full_no_write", 32'(WriteReg), 32'd0);
    cycle();
    InValid = 1'b0; Stall = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      check("drain_order", {11'd0, WriteReg, DstReg, DstData}, {11'd0, 1'b1, 4'(r), 16'(r)});
      cycle();
    end
    @(negedge clk);
    check("drain_empty", 32'(Count), 32'd0);

    // Forwarding: youngest wins, same-cycle push invisible, head visible.
    cycle();
    Stall = 1'b1; InValid = 1'b1; InReg = 4'd5; InData = 16'h1111;
    QryReg1 = 4'd5; QryReg2 = 4'd0;
    @(negedge clk);
    check("fwd_push_invisible", 32'(QryHit1), 32'd0);
    cycle();
    InData = 16'h2222;
    @(negedge clk);
    check("fwd_first", {15'd0, QryHit1, QryData1}, {15'd0, 1'b1, 16'h1111});
    cycle();
    InValid = 1'b0;
    @(negedge clk);
    check("fwd_youngest", {15'd0, QryHit1, QryData1}, {15'd0, 1'b1, 16'h2222});
    check("fwd_r0_miss", {15'd0, QryHit2, QryData2}, 32'd0);
    cycle();
    QryReg1 = 4'd7; QryReg2 = 4'd5;
    @(negedge clk);
    check("fwd_miss_p1", {15'd0, QryHit1, QryData1}, 32'd0);
    check("fwd_hit_p2", {15'd0, QryHit2, QryData2}, {15'd0, 1'b1, 16'h2222});
    cycle();
    Stall = 1'b0;
    @(negedge clk);
    check("fwd_head_write_p2", {15'd0, QryHit2, QryData2}, {15'd0, 1'b1, 16'h2222});
    cycle();
    @(negedge clk);
    check("fwd_last_head_vis", {15'd0, QryHit2, QryData2}, {15'd0, 1'b1, 16'h2222});
    cycle();
    @(negedge clk);
    check("fwd_drained", {15'd0, QryHit2, QryData2}, 32'd0);

    // R0 drop.
    cycle();
    InValid = 1'b1; InReg = 4'd0; InData = 16'hFFFF;
    @(negedge clk);
    check("r0_inready", 32'(InReady), 32'd1);
    check("r0_no_write", 32'(WriteReg), 32'd0);
    cycle();
    InValid = 1'b0;
    @(negedge clk);
    check("r0_count", 32'(Count), 32'd0);
    check("r0_no_write_after", 32'(WriteReg), 32'd0);

    // Stream of 10 results with alternating Stall across pointer wrap.
    i = 0; cyc = 0;
    cycle();
    while (i < 10 && cyc < 200) begin
      InValid = 1'b1; InReg = 4'((i % 15) + 1); InData = 16'hA000 + 16'(i);
      Stall = cyc[0];
      @(negedge clk);
      acc = (occ < DEPTH);
      cycle();
      if (acc) i++;
      cyc++;
    end
    check("stream_issued", 32'(i), 32'd10);
    InValid = 1'b0; Stall = 1'b0;
    cyc = 0;
    while (occ != 0 && cyc < 20) begin
      cycle();
      cyc++;
    end
    @(negedge clk);
    check("stream_all_written", 32'(exp_q.size()), 32'd0);
    check("stream_count", 32'(Count), 32'd0);

    // Reset mid-operation discards queued entries.
    cycle();
    Stall = 1'b1;
    for (int r = 7; r <= 9; r++) begin
      InValid = 1'b1; InReg = 4'(r); InData = 16'h0101 * 16'(r);
      cycle();
    end
    InValid = 1'b0; QryReg1 = 4'd7; QryReg2 = 4'd8;
    @(negedge clk);
    check("pre_rst_count", 32'(Count), 32'd3);
    check("pre_rst_hit1", {15'd0, QryHit1, QryData1}, {15'd0, 1'b1, 16'h0707});
    cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_writereg", 32'(WriteReg), 32'd0);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(Count), 32'd0);
    check("post_rst_hit1", {15'd0, QryHit1, QryData1}, 32'd0);
    check("post_rst_hit2", {15'd0, QryHit2, QryData2}, 32'd0);
    cycle();
    Stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_write", 32'(WriteReg), 32'd0);
      cycle();
    end

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
